// File: rtl/dsp_regfile_pkg.sv
// Shared definitions for the DSP register file: word/address sizes, register
// count, pending-counter width and the hard-wired zero register address.
package dsp_regfile_pkg;

   localparam int REG_WORD_LEN = 16;
   localparam int REG_ADDR_LEN = 4;
   localparam int NUM_REGS     = 16;
   localparam int PEND_W       = 2;

   localparam logic [REG_ADDR_LEN-1:0] R0_ADDR = '0;

endpackage

// File: rtl/dsp_pend_ctr.sv
// Saturating up/down counter tracking in-flight writes to one register.
// Overflow or underflow raises a sticky error that only reset clears.
module dsp_pend_ctr
   import dsp_regfile_pkg::*;
#(
   parameter int W = PEND_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         busy,
   output logic         err
);

   localparam logic [W-1:0] CNT_MAX = '1;

   // A simultaneous reserve and writeback cancel out, so only one-sided
   // requests move the counter; at either limit the count holds and err sets.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         err   <= 1'b0;
      end else if (inc && !dec) begin
         if (count == CNT_MAX) err <= 1'b1;
         else                  count <= count + W'(1);
      end else if (dec && !inc) begin
         if (count == '0) err <= 1'b1;
         else             count <= count - W'(1);
      end
   end

   assign busy = (count != '0);

endmodule

// File: rtl/dsp_regfile.sv
// DSP-pipeline register file: writeback port, two registered read ports with
// write-through bypass, and per-register pending counters for RAW stalls.
module dsp_regfile #(
   parameter int DATA_W   = dsp_regfile_pkg::REG_WORD_LEN,
   parameter int NUM_REGS = dsp_regfile_pkg::NUM_REGS,
   parameter int ADDR_W   = dsp_regfile_pkg::REG_ADDR_LEN,
   parameter int PEND_W   = dsp_regfile_pkg::PEND_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              stall,
   output logic              pend_err
);

   import dsp_regfile_pkg::*;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] next_a;
   logic [DATA_W-1:0] next_b;
   logic [PEND_W-1:0] pend_cnt [NUM_REGS];
   logic [NUM_REGS-1:0] pend_busy;
   logic [NUM_REGS-1:0] pend_errs;
   logic hazard_a;
   logic hazard_b;

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_en && wr_addr != R0_ADDR) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // A same-cycle writeback to the read address is forwarded so decode sees
   // the new value without waiting an extra cycle.
   always_comb begin
      next_a = regs[rd_addr_a];
      next_b = regs[rd_addr_b];
      if (wr_en && wr_addr == rd_addr_a) next_a = wr_data;
      if (wr_en && wr_addr == rd_addr_b) next_b = wr_data;
      if (rd_addr_a == R0_ADDR) next_a = '0;
      if (rd_addr_b == R0_ADDR) next_b = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_a <= '0;
         rd_data_b <= '0;
      end else if (rd_en) begin
         rd_data_a <= next_a;
         rd_data_b <= next_b;
      end
   end

   assign pend_cnt[0]  = '0;
   assign pend_busy[0] = 1'b0;
   assign pend_errs[0] = 1'b0;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_pend
      dsp_pend_ctr #(.W(PEND_W)) u_ctr (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (rsv_en && rsv_addr == ADDR_W'(g)),
         .dec   (wr_en && wr_addr == ADDR_W'(g)),
         .count (pend_cnt[g]),
         .busy  (pend_busy[g]),
         .err   (pend_errs[g])
      );
   end

   // The last outstanding write landing this cycle is bypassed, so it clears
   // the hazard early instead of costing a stall cycle.
   assign hazard_a = (rd_addr_a != R0_ADDR) && pend_busy[rd_addr_a] &&
                     !(wr_en && wr_addr == rd_addr_a && pend_cnt[rd_addr_a] == PEND_W'(1));
   assign hazard_b = (rd_addr_b != R0_ADDR) && pend_busy[rd_addr_b] &&
                     !(wr_en && wr_addr == rd_addr_b && pend_cnt[rd_addr_b] == PEND_W'(1));

   assign stall    = rd_en && (hazard_a || hazard_b);
   assign pend_err = |pend_errs;

endmodule

// File: doc/dsp_regfile.md
Name: dsp_regfile

Overview:
- DSP-pipeline register file: the receiving end of the writeback stage.
- Accepts the writeback data/enable pair and serves two registered read ports to decode.
- Tracks in-flight destination writes with a per-register pending counter, so decode can stall on RAW hazards.
- Sits between the writeback stage (write side) and the decode stage (read and reserve side).

Parameters:
- DATA_W, 16, register word width; equals the shared REG_WORD_LEN.
- NUM_REGS, 16, number of architectural registers.
- ADDR_W, 4, register address width, clog2(NUM_REGS).
- PEND_W, 2, width of each per-register pending-write counter.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  writeback enable. This is the level write_back_en, NOT the clock-gated regfile write enable.
- wr_addr  input  ADDR_W  writeback destination register.
- wr_data  input  DATA_W  writeback data.
- rd_en  input  1  decode read strobe.
- rd_addr_a  input  ADDR_W  read port A address.
- rd_addr_b  input  ADDR_W  read port B address.
- rd_data_a  output  DATA_W  registered read data A.
- rd_data_b  output  DATA_W  registered read data B.
- rsv_en  input  1  decode issues an instruction that will write rsv_addr.
- rsv_addr  input  ADDR_W  destination being reserved.
- stall  output  1  combinational RAW-hazard indication to decode.
- pend_err  output  1  sticky error flag: pending counter overflow or underflow.

Behaviour:
- Reset (async, rst_n low):
  - all registers 0, all pending counters 0;
  - rd_data_a/b 0, pend_err 0;
  - takes effect immediately, mid-operation included; any in-flight reservations are discarded.
- Register 0:
  - always reads 0;
  - writes to it are ignored;
  - reserves to it are ignored and never raise stall.
- Write: on posedge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
- Read:
  - on posedge with rd_en=1, rd_data_x <= value of reg[rd_addr_x]; latency 1 cycle.
  - With rd_en=0, outputs hold their previous values.
- Write-through bypass:
  - if wr_en=1, wr_addr==rd_addr_x and rd_addr_x!=0 in the same cycle, rd_data_x <= wr_data (new value, not old).
  - This replaces the half-cycle write/read timing.
- Pending counters (pend[r], PEND_W bits):
  - rsv_en only (rsv_addr!=0): pend[rsv_addr]+1.
  - wr_en only (wr_addr!=0): pend[wr_addr]-1.
  - Both, same address: net unchanged.
  - Both, different addresses: each updates independently.
  - Increment at max value (3): counter saturates, pend_err <= 1.
  - Decrement at 0: counter stays 0, pend_err <= 1.
  - pend_err clears only on reset.
- stall = rd_en & (hazard_a | hazard_b), where hazard_x = (rd_addr_x!=0) & (pend[rd_addr_x]!=0) & ~(wr_en & wr_addr==rd_addr_x & pend[rd_addr_x]==1).
  - The last term: the final outstanding write, arriving this cycle, is bypassed, so no stall.
- Read while stall=1: rd_data still updates; decode discards it. The regfile does not gate reads.
- rsv_en and stall in the same cycle: the reservation is still counted. Decode must not assert rsv_en while stalled; this is a checker assertion, not RTL logic.

Decomposition:
- Shared package / definitions: REG_WORD_LEN, REG_ADDR_LEN, NUM_REGS, PEND_W, and the R0 address constant.
- One sub-module, dsp_pend_ctr: a single saturating up/down counter with inc/dec inputs, busy and err outputs.
- Instantiate dsp_pend_ctr NUM_REGS-1 times; register 0 has no counter.
- Storage array and read muxes stay in the top module.

Test Plan:
- Reset: write reg3=0x1234, assert rst_n=0 mid-cycle → rd_data_a/b=0 immediately; after release, read reg3 → 0x0000.
- Write/read and R0:
  - write reg5=0xBEEF, next cycle read a=5 → rd_data_a=0xBEEF one cycle later;
  - write reg0=0xFFFF, read 0 → 0x0000.
- Bypass: same cycle wr_en=1, wr_addr=7, wr_data=0xA5A5, rd_addr_a=7, rd_addr_b=7, rd_en=1 → next cycle both outputs 0xA5A5.
- Hazard:
  - rsv reg4, then read a=4 → stall=1 until writeback;
  - the write to reg4 arriving in the read cycle → stall=0 in that cycle, data bypassed.
- Double reservation:
  - rsv reg2 twice, one write to reg2 → stall stays 1 for reads of reg2; second write → stall=0.
  - rsv and write to reg2 in the same cycle → count unchanged.
- Error:
  - 4 rsv to reg9 without writes → pend_err=1, counter stays 3;
  - separately, after reset, a write to reg6 with pend=0 → pend_err=1, reg6 still updated.
